// File: rtl/alu_issue_stage.sv
// Decode-and-issue ID/EX register feeding the execute-stage ALU (RV32I subset).
// Optional feature: define ALU_ISSUE_ILLEGAL_TRAP_EN to trap illegal instructions instead of issuing NOPs.
module alu_issue_stage #(
   parameter int XLEN = 32
) (
   input  logic            Clk_i,
   input  logic            Rst_ni,
   input  logic            Valid_i,
   output logic            Ready_o,
   input  logic [31:0]     Instr_i,
   input  logic [XLEN-1:0] Pc_i,
   input  logic [XLEN-1:0] Rs1Data_i,
   input  logic [XLEN-1:0] Rs2Data_i,
   input  logic            Flush_i,
   output logic            Valid_o,
   input  logic            Ready_i,
   output logic [3:0]      AluOp_o,
   output logic [XLEN-1:0] AluInA_o,
   output logic [XLEN-1:0] AluInB_o,
   output logic [XLEN-1:0] StoreData_o,
   output logic [4:0]      Rd_o,
   output logic            RegWrite_o,
   output logic            MemRead_o,
   output logic            MemWrite_o,
   output logic            IllegalInstr_o
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   // Shared funct3 mapping for OP and OP-IMM; the alternate-funct7 forms are patched by the caller.
   function automatic logic [3:0] f3_to_op(input logic [2:0] f3);
      logic [3:0] op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [6:0]      funct7_s;
   logic [4:0]      rd_s;
   logic [XLEN-1:0] imm_i_s;
   logic [XLEN-1:0] imm_s_s;
   logic [XLEN-1:0] imm_u_s;
   logic [XLEN-1:0] shamt_s;

   assign opcode_s = Instr_i[6:0];
   assign funct3_s = Instr_i[14:12];
   assign funct7_s = Instr_i[31:25];
   assign rd_s     = Instr_i[11:7];
   assign imm_i_s  = {{(XLEN-12){Instr_i[31]}}, Instr_i[31:20]};
   assign imm_s_s  = {{(XLEN-12){Instr_i[31]}}, Instr_i[31:25], Instr_i[11:7]};
   assign imm_u_s  = {Instr_i[31:12], 12'b0000_0000_0000};
   assign shamt_s  = {{(XLEN-5){1'b0}}, Instr_i[24:20]};

   logic [3:0]      op_s;
   logic [XLEN-1:0] a_s;
   logic [XLEN-1:0] b_s;
   logic            reg_write_s;
   logic            mem_read_s;
   logic            mem_write_s;
   logic            illegal_s;

   // Instruction decode into raw op, operands and write enables.
   always_comb begin
      op_s        = ALU_ADD;
      a_s         = Rs1Data_i;
      b_s         = imm_i_s;
      reg_write_s = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      illegal_s   = 1'b0;
      case (opcode_s)
         OPC_OP: begin
            b_s         = Rs2Data_i;
            reg_write_s = 1'b1;
            if (funct7_s == F7_ZERO) begin
               op_s = f3_to_op(funct3_s);
            end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
               op_s = ALU_SUB;
            end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
               op_s = ALU_SRA;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            reg_write_s = 1'b1;
            op_s        = f3_to_op(funct3_s);
            case (funct3_s)
               3'b001: begin
                  b_s       = shamt_s;
                  illegal_s = (funct7_s != F7_ZERO);
               end
               3'b101: begin
                  b_s = shamt_s;
                  if (funct7_s == F7_ZERO) begin
                     op_s = ALU_SRL;
                  end else if (funct7_s == F7_ALT) begin
                     op_s = ALU_SRA;
                  end else begin
                     illegal_s = 1'b1;
                  end
               end
               default: b_s = imm_i_s;
            endcase
         end
         OPC_LUI: begin
            a_s         = {XLEN{1'b0}};
            b_s         = imm_u_s;
            reg_write_s = 1'b1;
         end
         OPC_AUIPC: begin
            a_s         = Pc_i;
            b_s         = imm_u_s;
            reg_write_s = 1'b1;
         end
         OPC_LOAD: begin
            mem_read_s  = 1'b1;
            reg_write_s = 1'b1;
         end
         OPC_STORE: begin
            b_s         = imm_s_s;
            mem_write_s = 1'b1;
         end
         default: illegal_s = 1'b1;
      endcase
   end

   logic [3:0] fin_op_s;
   logic       fin_reg_write_s;
   logic       fin_mem_read_s;
   logic       fin_mem_write_s;
   logic       entry_valid_s;

   // Illegal instructions degrade to a side-effect-free ADD; writes to x0 are dropped.
   always_comb begin
      fin_op_s        = illegal_s ? ALU_ADD : op_s;
      fin_reg_write_s = reg_write_s && !illegal_s && (rd_s != 5'd0);
      fin_mem_read_s  = mem_read_s && !illegal_s;
      fin_mem_write_s = mem_write_s && !illegal_s;
      entry_valid_s   = !(illegal_s && TRAP_EN);
   end

   logic            valid_r;
   logic [3:0]      op_r;
   logic [XLEN-1:0] a_r;
   logic [XLEN-1:0] b_r;
   logic [XLEN-1:0] store_r;
   logic [4:0]      rd_r;
   logic            reg_write_r;
   logic            mem_read_r;
   logic            mem_write_r;
   logic            illegal_r;
   logic            ready_s;
   logic            load_s;

   assign ready_s = !valid_r || Ready_i;
   assign load_s  = Valid_i && ready_s;

   // ID/EX entry: flush beats load, load beats retire, otherwise hold under back-pressure.
   always_ff @(posedge Clk_i or negedge Rst_ni) begin
      if (!Rst_ni) begin
         valid_r     <= 1'b0;
         op_r        <= ALU_ADD;
         a_r         <= {XLEN{1'b0}};
         b_r         <= {XLEN{1'b0}};
         store_r     <= {XLEN{1'b0}};
         rd_r        <= 5'd0;
         reg_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         illegal_r   <= 1'b0;
      end else if (Flush_i) begin
         valid_r     <= 1'b0;
         reg_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         illegal_r   <= 1'b0;
      end else if (load_s) begin
         valid_r     <= entry_valid_s;
         op_r        <= fin_op_s;
         a_r         <= a_s;
         b_r         <= b_s;
         store_r     <= Rs2Data_i;
         rd_r        <= rd_s;
         reg_write_r <= fin_reg_write_s && entry_valid_s;
         mem_read_r  <= fin_mem_read_s && entry_valid_s;
         mem_write_r <= fin_mem_write_s && entry_valid_s;
         illegal_r   <= illegal_s && TRAP_EN;
      end else if (ready_s) begin
         valid_r     <= 1'b0;
         reg_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         illegal_r   <= 1'b0;
      end else begin
         illegal_r   <= 1'b0;
      end
   end

   assign Ready_o        = ready_s;
   assign Valid_o        = valid_r;
   assign AluOp_o        = op_r;
   assign AluInA_o       = a_r;
   assign AluInB_o       = b_r;
   assign StoreData_o    = store_r;
   assign Rd_o           = rd_r;
   assign RegWrite_o     = reg_write_r;
   assign MemRead_o      = mem_read_r;
   assign MemWrite_o     = mem_write_r;
   assign IllegalInstr_o = illegal_r;

endmodule
